// File: rtl/mdr_pkg.sv
// Shared types, widths and helpers for the multiply / divide / square-root unit.
package pkg_system_mdr;

  localparam int DW = 16;
  // Internal accumulator width: one guard bit for Booth on -2^15, one for the trial-subtract sign.
  localparam int AW = DW + 2;

  localparam int MULDIV_ITERS = DW;
  localparam int ROOT_ITERS   = DW / 2;

  typedef logic signed [DW-1:0]   data_in_t;
  typedef logic signed [2*DW-1:0] data_t;
  typedef logic signed [DW-1:0]   reminder_t;
  typedef logic signed [AW-1:0]   acc_t;

  typedef enum logic [1:0] {
    MULT = 2'd0,
    DIV  = 2'd1,
    ROOT = 2'd2
  } op_select_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_X = 3'd1,
    ST_LOAD_Y = 3'd2,
    ST_CALC   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  function automatic logic [DW-1:0] magnitude(input data_in_t v);
    return v[DW-1] ? DW'(-v) : DW'(v);
  endfunction

  function automatic logic [3:0] last_iteration(input logic [1:0] op);
    return (op == ROOT) ? 4'(ROOT_ITERS - 1) : 4'(MULDIV_ITERS - 1);
  endfunction

endpackage

// File: rtl/mdr_edge_detect.sv
// Registers an active-low strobe and emits a one-clock pulse on its falling edge.
module mdr_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_strobe_n,
  output logic o_pulse
);

  logic r_cap;
  logic r_prev;
  logic r_arm;

  // r_arm stays low until the strobe is seen high, so a button held through reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap  <= 1'b1;
      r_prev <= 1'b1;
      r_arm  <= 1'b0;
    end else begin
      // NOTE: non-blocking so r_prev takes the value r_cap held before this edge.
      r_cap  <= i_strobe_n;
      r_prev <= r_cap;
      r_arm  <= r_arm | i_strobe_n;
    end
  end

  assign o_pulse = r_arm & r_prev & ~r_cap;

endmodule

// File: rtl/mdr.sv
// Sequential signed multiply / divide / square-root unit with a two-operand load handshake.
module mdr
  import pkg_system_mdr::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_load,
  input  data_in_t   i_data,
  input  op_select_t i_op,
  output data_t      o_result,
  output reminder_t  o_reminder,
  output logic       o_load_x,
  output logic       o_load_y,
  output logic       o_error
);

  logic          w_start_pulse;
  logic          w_load_pulse;

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_op;

  data_in_t      r_x;
  logic          r_y_neg;
  acc_t          r_acc;
  acc_t          r_m;
  logic [DW-1:0] r_q;
  logic          r_q1;
  logic [7:0]    r_root;
  logic [3:0]    r_cnt;

  data_t         r_result;
  reminder_t     r_reminder;
  logic          r_error;
  logic          r_load_x;
  logic          r_load_y;

  acc_t          w_add_a;
  acc_t          w_add_b;
  acc_t          w_sum;
  logic          w_add_sub;
  acc_t          w_booth;
  acc_t          w_acc_next;
  logic [DW-1:0] w_q_next;
  logic          w_q1_next;
  logic [7:0]    w_root_next;
  data_t         w_div_q;
  data_t         w_calc_result;
  reminder_t     w_calc_rem;

  logic          w_last;
  logic          w_err_cond;
  logic          w_calc_done;
  logic          w_err_entry;
  logic          w_calc_start;
  logic          w_capture_x;

  mdr_edge_detect u_start_edge (
    .clk        (clk),
    .rst        (rst),
    .i_strobe_n (i_start),
    .o_pulse    (w_start_pulse)
  );

  mdr_edge_detect u_load_edge (
    .clk        (clk),
    .rst        (rst),
    .i_strobe_n (i_load),
    .o_pulse    (w_load_pulse)
  );

  assign w_last     = (r_cnt == last_iteration(r_op));
  assign w_err_cond = (r_op == 2'd3)
                   || ((r_op == DIV) && (i_data == '0))
                   || ((r_op == ROOT) && r_x[DW-1]);

  always_comb begin
    // NOTE: default first so no path through this block leaves the next state unassigned.
    w_state_next = r_state;
    if (w_start_pulse) begin
      w_state_next = ST_LOAD_X;
    end else begin
      case (r_state)
        ST_LOAD_X: if (w_load_pulse) w_state_next = ST_LOAD_Y;
        ST_LOAD_Y: if (w_load_pulse) w_state_next = w_err_cond ? ST_ERR : ST_CALC;
        ST_CALC:   if (w_last)       w_state_next = ST_DONE;
        ST_IDLE, ST_DONE, ST_ERR: ;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  assign w_capture_x  = (r_state == ST_LOAD_X) && (w_state_next == ST_LOAD_Y);
  assign w_calc_start = (r_state == ST_LOAD_Y) && (w_state_next == ST_CALC);
  assign w_err_entry  = (r_state == ST_LOAD_Y) && (w_state_next == ST_ERR);
  assign w_calc_done  = (r_state == ST_CALC)   && (w_state_next == ST_DONE);

  // One adder serves all three algorithms; the op selects its operands and direction.
  always_comb begin
    w_add_a   = r_acc;
    w_add_b   = r_m;
    w_add_sub = 1'b1;
    case (r_op)
      MULT: w_add_sub = r_q[0];
      DIV:  w_add_a   = {1'b0, r_acc[DW-1:0], r_q[DW-1]};
      ROOT: begin
        w_add_a = {r_acc[DW-1:0], r_q[DW-1 -: 2]};
        w_add_b = {{(AW-10){1'b0}}, r_root, 2'b01};
      end
      default: ;
    endcase
  end

  assign w_sum = w_add_sub ? (w_add_a - w_add_b) : (w_add_a + w_add_b);

  always_comb begin
    w_booth     = r_acc;
    w_acc_next  = r_acc;
    w_q_next    = r_q;
    w_q1_next   = r_q1;
    w_root_next = r_root;
    case (r_op)
      MULT: begin
        w_booth    = (r_q[0] ^ r_q1) ? w_sum : r_acc;
        w_acc_next = {w_booth[AW-1], w_booth[AW-1:1]};
        w_q_next   = {w_booth[0], r_q[DW-1:1]};
        w_q1_next  = r_q[0];
      end
      DIV: begin
        w_acc_next = w_sum[AW-1] ? w_add_a : w_sum;
        w_q_next   = {r_q[DW-2:0], ~w_sum[AW-1]};
      end
      ROOT: begin
        w_acc_next  = w_sum[AW-1] ? w_add_a : w_sum;
        w_q_next    = {r_q[DW-3:0], 2'b00};
        w_root_next = {r_root[6:0], ~w_sum[AW-1]};
      end
      default: ;
    endcase
  end

  assign w_div_q = {{DW{1'b0}}, w_q_next};

  // Final iteration's values are used directly so results land on the last CALC edge.
  always_comb begin
    w_calc_result = '0;
    w_calc_rem    = '0;
    case (r_op)
      MULT: w_calc_result = {w_acc_next[DW-1:0], w_q_next};
      DIV: begin
        w_calc_result = (r_x[DW-1] ^ r_y_neg) ? -w_div_q : w_div_q;
        w_calc_rem    = r_x[DW-1] ? -w_acc_next[DW-1:0] : w_acc_next[DW-1:0];
      end
      ROOT: begin
        w_calc_result = {{(2*DW-8){1'b0}}, w_root_next};
        w_calc_rem    = w_acc_next[DW-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_load_x   <= 1'b0;
      r_load_y   <= 1'b0;
      r_result   <= '0;
      r_reminder <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_load_x <= (w_state_next == ST_LOAD_X);
      r_load_y <= (w_state_next == ST_LOAD_Y);
      if (w_start_pulse) begin
        r_op       <= i_op;
        r_result   <= '0;
        r_reminder <= '0;
        r_error    <= 1'b0;
      end else if (w_calc_done) begin
        r_result   <= w_calc_result;
        r_reminder <= w_calc_rem;
      end else if (w_err_entry) begin
        r_result   <= '0;
        r_reminder <= '0;
        r_error    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y_neg <= 1'b0;
      r_acc   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_root  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_capture_x) begin
        r_x <= i_data;
      end
      if (w_calc_start) begin
        r_y_neg <= i_data[DW-1];
        r_acc   <= '0;
        r_q1    <= 1'b0;
        r_root  <= '0;
        r_cnt   <= '0;
        case (r_op)
          MULT: begin
            r_m <= {{(AW-DW){r_x[DW-1]}}, r_x};
            r_q <= i_data;
          end
          DIV: begin
            r_m <= {{(AW-DW){1'b0}}, magnitude(i_data)};
            r_q <= magnitude(r_x);
          end
          default: begin
            r_m <= '0;
            r_q <= r_x;
          end
        endcase
      end else if (r_state == ST_CALC) begin
        r_acc  <= w_acc_next;
        r_q    <= w_q_next;
        r_q1   <= w_q1_next;
        r_root <= w_root_next;
        r_cnt  <= r_cnt + 4'd1;
      end
    end
  end

  assign o_result   = r_result;
  assign o_reminder = r_reminder;
  assign o_error    = r_error;
  assign o_load_x   = r_load_x;
  assign o_load_y   = r_load_y;

endmodule

// File: tb/tb_mdr.sv
// Self-checking bench for mdr: directed vector table, random ops against an arithmetic model, corner sequences.
module tb_mdr;
  import pkg_system_mdr::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic       i_load;
  data_in_t   i_data;
  op_select_t i_op;
  data_t      o_result;
  reminder_t  o_reminder;
  logic       o_load_x;
  logic       o_load_y;
  logic       o_error;

  int n_checks = 0;
  int n_errors = 0;

  mdr dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_load     (i_load),
    .i_data     (i_data),
    .i_op       (i_op),
    .o_result   (o_result),
    .o_reminder (o_reminder),
    .o_load_x   (o_load_x),
    .o_load_y   (o_load_y),
    .o_error    (o_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    int         x;
    int         y;
    int         exp_res;
    int         exp_rem;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: plain integer arithmetic; SV int division truncates toward zero like the unit.
  function automatic void model(input logic [1:0] op, input int x, input int y,
                                output int res, output int rem, output logic err);
    int r;
    res = 0;
    rem = 0;
    err = 1'b0;
    if (op == 2'd3 || (op == 2'd1 && y == 0) || (op == 2'd2 && x < 0)) begin
      err = 1'b1;
    end else if (op == 2'd0) begin
      res = x * y;
    end else if (op == 2'd1) begin
      res = x / y;
      rem = x % y;
    end else begin
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      res = r;
      rem = x - r * r;
    end
  endfunction

  task automatic press_start();
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    i_start = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic press_load();
    @(negedge clk);
    i_load = 1'b0;
    repeat (3) @(negedge clk);
    i_load = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input logic [1:0] op, input int x, input int y);
    i_op = op_select_t'(op);
    press_start();
    check("start_load_x", o_load_x, 1);
    check("start_load_y", o_load_y, 0);
    check("start_clears_error", o_error, 0);
    check("start_clears_result", o_result, 0);
    i_data = data_in_t'(x);
    press_load();
    check("xload_load_x", o_load_x, 0);
    check("xload_load_y", o_load_y, 1);
    i_data = data_in_t'(y);
    press_load();
    repeat (20) @(negedge clk);
    check("end_load_x", o_load_x, 0);
    check("end_load_y", o_load_y, 0);
  endtask

  task automatic check_outputs(input string tag, input int exp_res, input int exp_rem, input logic exp_err);
    check({tag, "_result"}, o_result, exp_res);
    check({tag, "_rem"}, o_reminder, exp_rem);
    check({tag, "_error"}, o_error, exp_err);
  endtask

  vec_t vecs[$];
  int   m_res, m_rem;
  logic m_err;
  int   rx, ry;
  logic [1:0] rop;
  logic signed [15:0] t16;
  int   edge_vals[6] = '{-32768, -1, 0, 1, 32767, 2};

  initial begin
    rst     = 1'b1;
    i_start = 1'b1;
    i_load  = 1'b1;
    i_data  = '0;
    i_op    = MULT;

    vecs.push_back('{2'd2,     25,      0,          5,  0, 1'b0});
    vecs.push_back('{2'd2,     26,      0,          5,  1, 1'b0});
    vecs.push_back('{2'd0,      7,     -3,        -21,  0, 1'b0});
    vecs.push_back('{2'd0, -32768, -32768, 1073741824,  0, 1'b0});
    vecs.push_back('{2'd1,    100,      7,         14,  2, 1'b0});
    vecs.push_back('{2'd1,   -100,      7,        -14, -2, 1'b0});
    vecs.push_back('{2'd1,      5,      0,          0,  0, 1'b1});
    vecs.push_back('{2'd2,     -4,      9,          0,  0, 1'b1});
    vecs.push_back('{2'd3,      1,      2,          0,  0, 1'b1});
    vecs.push_back('{2'd1, -32768,     -1,      32768,  0, 1'b0});
    vecs.push_back('{2'd2,  32767,      0,        181,  6, 1'b0});
    vecs.push_back('{2'd0,  32767, -32768, -1073709056, 0, 1'b0});
    vecs.push_back('{2'd1,      7,     -2,         -3,  1, 1'b0});
    vecs.push_back('{2'd2,      0,      0,          0,  0, 1'b0});

    repeat (3) @(negedge clk);
    check("reset_result", o_result, 0);
    check("reset_rem", o_reminder, 0);
    check("reset_error", o_error, 0);
    check("reset_load_x", o_load_x, 0);
    check("reset_load_y", o_load_y, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].x, vecs[i].y);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_rem, vecs[i].exp_err);
    end

    // Randomized ops against the model, with boundary operands mixed in.
    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom_range(0, 3));
      t16 = 16'($urandom);
      rx  = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 5)] : int'(t16);
      t16 = 16'($urandom);
      ry  = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 5)] : int'(t16);
      if (rop == 2'd2 && $urandom_range(0, 1) == 1 && rx < 0) rx = -rx - 1;
      model(rop, rx, ry, m_res, m_rem, m_err);
      run_op(rop, rx, ry);
      check_outputs($sformatf("rnd%0d_op%0d_x%0d_y%0d", n, rop, rx, ry), m_res, m_rem, m_err);
    end

    // Results stay 0 partway through CALC, then appear.
    i_op = ROOT;
    press_start();
    i_data = 16'sd25;
    press_load();
    i_data = 16'sd0;
    @(negedge clk);
    i_load = 1'b0;
    repeat (3) @(negedge clk);
    i_load = 1'b1;
    repeat (3) @(negedge clk);
    check("midcalc_result", o_result, 0);
    check("midcalc_load_y", o_load_y, 0);
    repeat (6) @(negedge clk);
    check_outputs("root_timed", 5, 0, 1'b0);

    // Load in DONE is ignored.
    i_data = 16'sd99;
    press_load();
    check_outputs("done_load_ignored", 5, 0, 1'b0);

    // Start during CALC aborts and restarts with the new op.
    i_op = MULT;
    press_start();
    i_data = 16'sd7;
    press_load();
    i_data = -16'sd3;
    press_load();
    i_op = ROOT;
    press_start();
    check("abort_load_x", o_load_x, 1);
    check("abort_result", o_result, 0);
    i_data = 16'sd26;
    press_load();
    i_data = 16'sd0;
    press_load();
    repeat (20) @(negedge clk);
    check_outputs("abort_root", 5, 1, 1'b0);

    // Start and load together in LOAD_Y: start wins.
    i_op = DIV;
    press_start();
    i_data = 16'sd100;
    press_load();
    @(negedge clk);
    i_start = 1'b0;
    i_load  = 1'b0;
    repeat (3) @(negedge clk);
    i_start = 1'b1;
    i_load  = 1'b1;
    repeat (2) @(negedge clk);
    check("both_load_x", o_load_x, 1);
    check("both_load_y", o_load_y, 0);
    i_data = 16'sd100;
    press_load();
    i_data = 16'sd7;
    press_load();
    repeat (20) @(negedge clk);
    check_outputs("both_div", 14, 2, 1'b0);

    // Reset from DONE clears outputs; reset mid-CALC stops the operation.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs("rst_done", 0, 0, 1'b0);
    i_op = MULT;
    press_start();
    i_data = 16'sd7;
    press_load();
    i_data = -16'sd3;
    press_load();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs("rst_calc", 0, 0, 1'b0);
    check("rst_calc_load_x", o_load_x, 0);
    repeat (20) @(negedge clk);
    check_outputs("rst_calc_later", 0, 0, 1'b0);

    // Start held low across reset release must not start an operation.
    i_start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("held_start_load_x", o_load_x, 0);
    i_start = 1'b1;
    repeat (2) @(negedge clk);
    run_op(2'd1, -100, 7);
    check_outputs("after_held", -14, -2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
